// File: rtl/uart_tx.sv
// uart_tx - 8N1 byte serializer with runtime bit period.
//
// Accepts one byte over a valid/ack handshake and shifts it out as
// idle-high asynchronous serial: one start bit, 8 data bits LSB first,
// one stop bit. Bit period P = div + 2 clk cycles, captured per frame.
//
// Ports:
//   clk   in  1      system clock
//   rst   in  1      asynchronous active-low reset
//   data  in  8      byte to send, sampled on the accept edge
//   valid in  1      byte available on data (may be held high)
//   ack   out 1      one-cycle pulse in the cycle after an accept edge
//   div   in  DIV_W  bit period minus 2, sampled on the accept edge
//   tx    out 1      serial line, idle high
//   busy  out 1      high from start bit through stop bit
module uart_tx #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             valid,
  output logic             ack,
  input  logic [DIV_W-1:0] div,
  output logic             tx,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state;
  logic [7:0]       r_shreg;
  logic [DIV_W-1:0] r_div_q;
  logic [DIV_W:0]   r_cnt;     // one bit wider so div_q+1 cannot overflow
  logic [2:0]       r_bidx;
  logic             r_ack;

  logic             w_bit_end;
  logic             w_accept;

  assign w_bit_end = (r_cnt == ({1'b0, r_div_q} + (DIV_W+1)'(1)));

  // Accept either from IDLE or at the end of a stop bit, so back-to-back
  // frames have no idle gap.
  assign w_accept  = valid &&
                     ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_div_q <= '0;
      r_cnt   <= '0;
      r_bidx  <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= w_accept;
      if (w_accept) begin
        r_shreg <= data;
        r_div_q <= div;
        r_cnt   <= '0;
        r_bidx  <= '0;
        r_state <= S_START;
      end else if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_cnt <= '0;
          case (r_state)
            S_START: r_state <= S_DATA;
            S_DATA: begin
              r_shreg <= {1'b0, r_shreg[7:1]};
              r_bidx  <= r_bidx + 3'd1;
              if (r_bidx == 3'd7) begin
                r_state <= S_STOP;
              end
            end
            default: r_state <= S_IDLE;  // stop bit ended with no byte waiting
          endcase
        end else begin
          r_cnt <= r_cnt + (DIV_W+1)'(1);
        end
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      S_START: tx = 1'b0;
      S_DATA:  tx = r_shreg[0];
      default: tx = 1'b1;
    endcase
  end

  assign busy = (r_state != S_IDLE);
  assign ack  = r_ack;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

  localparam int unsigned DW   = 4;
  localparam int unsigned LOGN = 8192;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    data;
  logic          valid;
  logic [DW-1:0] div;
  logic          ack;
  logic          tx;
  logic          busy;

  uart_tx #(.DIV_W(DW)) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .valid (valid),
    .ack   (ack),
    .div   (div),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is 10 bit slots of m_p cycles each, slot 0
  // is the start bit, slots 1..8 the data bits LSB first, slot 9 the stop bit.
  bit          m_active = 1'b0;
  int unsigned m_t      = 0;
  int unsigned m_p      = 2;
  logic [7:0]  m_byte   = 8'h00;
  bit          m_ack    = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_ack    = 1'b0;
      m_t      = 0;
    end else begin
      m_ack = 1'b0;
      if (m_active) begin
        m_t++;
        if (m_t == 10 * m_p) m_active = 1'b0;
      end
      if (!m_active && valid) begin
        m_active = 1'b1;
        m_t      = 0;
        m_byte   = data;
        m_p      = 32'(div) + 2;
        m_ack    = 1'b1;
      end
    end
  end

  function automatic logic exp_tx();
    int unsigned slot;
    if (!m_active) return 1'b1;
    slot = m_t / m_p;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_byte[slot-1];
    return 1'b1;
  endfunction

  int unsigned cyc = 0;
  logic tx_log   [LOGN];
  logic busy_log [LOGN];
  logic ack_log  [LOGN];

  always @(negedge clk) begin
    chk("tx", {31'd0, tx}, {31'd0, exp_tx()});
    chk("busy", {31'd0, busy}, {31'd0, m_active});
    chk("ack", {31'd0, ack}, {31'd0, m_ack});
    if (cyc < LOGN) begin
      tx_log[cyc]   = tx;
      busy_log[cyc] = busy;
      ack_log[cyc]  = ack;
    end
    cyc++;
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_ack(input string name, input int unsigned maxc, output int unsigned idx);
    bit found;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 0; i < maxc && !found; i++) begin
      step();
      if (ack === 1'b1) begin
        found = 1'b1;
        idx   = cyc - 1;
      end
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no ack within %0d cycles, got none expected one", name, maxc);
    end
  endtask

  // sel: 0 = tx high, 1 = busy high, 2 = ack high
  function automatic int unsigned count_hi(input int unsigned sel, input int unsigned a,
                                           input int unsigned b);
    int unsigned n;
    n = 0;
    for (int unsigned i = a; i < b && i < LOGN; i++) begin
      if (sel == 0 && tx_log[i] === 1'b1) n++;
      if (sel == 1 && busy_log[i] === 1'b1) n++;
      if (sel == 2 && ack_log[i] === 1'b1) n++;
    end
    return n;
  endfunction

  // Host-side decoder sampling mid-bit
  function automatic logic [7:0] decode(input int unsigned s, input int unsigned p);
    logic [7:0] b;
    for (int unsigned k = 0; k < 8; k++) b[k] = tx_log[s + (k + 1) * p + p / 2];
    return b;
  endfunction

  initial begin
    int unsigned s, a0, a1, a2, b0, b1, c0, d0, d1, e0, e1, rel, f0;
    logic [9:0] pat;

    data  = 8'h00;
    valid = 1'b0;
    div   = '0;
    rst   = 1'b0;
    repeat (3) step();
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    rst = 1'b1;
    step();

    // Single byte 0xA5, P=12
    div   = 4'd10;
    data  = 8'hA5;
    valid = 1'b1;
    wait_ack("single_ack", 3, s);
    valid = 1'b0;
    repeat (125) step();
    pat = {1'b1, 8'hA5, 1'b0};
    for (int unsigned i = 0; i < 120; i++) chk("single_tx_bit", {31'd0, tx_log[s+i]}, {31'd0, pat[i/12]});
    chk("single_tx_after", {31'd0, tx_log[s+120]}, 32'd1);
    chk("single_busy_len", count_hi(1, s - 2, s + 124), 32'd120);
    chk("single_ack_cnt", count_hi(2, s - 2, s + 124), 32'd1);

    // Back-to-back 0xBE, 0xEF, 0x12
    data  = 8'hBE;
    valid = 1'b1;
    wait_ack("b2b_ack0", 3, a0);
    data = 8'hEF;
    wait_ack("b2b_ack1", 130, a1);
    data = 8'h12;
    wait_ack("b2b_ack2", 130, a2);
    valid = 1'b0;
    repeat (125) step();
    chk("b2b_gap1", a1 - a0, 32'd120);
    chk("b2b_gap2", a2 - a1, 32'd120);
    chk("b2b_byte0", {24'd0, decode(a0, 12)}, 32'hBE);
    chk("b2b_byte1", {24'd0, decode(a1, 12)}, 32'hEF);
    chk("b2b_byte2", {24'd0, decode(a2, 12)}, 32'h12);
    chk("b2b_busy_contig", count_hi(1, a0, a2 + 124), 32'd360);

    // Minimum divider, P=2
    div   = 4'd0;
    data  = 8'h00;
    valid = 1'b1;
    wait_ack("min_ack0", 3, b0);
    wait_ack("min_ack1", 25, b1);
    valid = 1'b0;
    repeat (25) step();
    chk("min_gap", b1 - b0, 32'd20);
    chk("min_tx_low", count_hi(0, b0, b0 + 18), 32'd0);
    chk("min_tx_stop", count_hi(0, b0 + 18, b0 + 20), 32'd2);

    // Idle with wiggling data/div
    c0 = cyc;
    for (int unsigned i = 0; i < 1000; i++) begin
      step();
      data = 8'($urandom);
      div  = DW'($urandom);
    end
    chk("idle_tx", count_hi(0, c0, c0 + 1000), 32'd1000);
    chk("idle_busy", count_hi(1, c0, c0 + 1000), 32'd0);
    chk("idle_ack", count_hi(2, c0, c0 + 1000), 32'd0);

    // Mid-frame div/data change
    div   = 4'd10;
    data  = 8'h0F;
    valid = 1'b1;
    wait_ack("mid_ack0", 3, d0);
    valid = 1'b0;
    repeat (4 * 12 + 5) step();
    div   = 4'd2;
    data  = 8'hFF;
    valid = 1'b1;
    wait_ack("mid_ack1", 120, d1);
    valid = 1'b0;
    repeat (45) step();
    chk("mid_gap", d1 - d0, 32'd120);
    chk("mid_byte0", {24'd0, decode(d0, 12)}, 32'h0F);
    chk("mid_byte1", {24'd0, decode(d1, 4)}, 32'hFF);
    chk("mid_busy1", count_hi(1, d1, d1 + 45), 32'd40);

    // Asynchronous reset during data bit 4
    div   = 4'd10;
    data  = 8'h33;
    valid = 1'b1;
    wait_ack("rst_ack0", 3, e0);
    valid = 1'b0;
    repeat (5 * 12 + 3) step();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_tx", {31'd0, tx}, 32'd1);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_ack", {31'd0, ack}, 32'd0);
    data  = 8'h55;
    valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    rel = cyc;
    wait_ack("rst_ack1", 5, e1);
    valid = 1'b0;
    repeat (125) step();
    chk("rst_first_accept", e1, rel);
    chk("rst_no_ack", count_hi(2, e0 + 1, e1), 32'd0);
    chk("rst_start_bit", {31'd0, tx_log[e1]}, 32'd0);
    chk("rst_byte", {24'd0, decode(e1, 12)}, 32'h55);
    chk("rst_busy_len", count_hi(1, e1, e1 + 125), 32'd120);

    // All-ones divider: P = 2^DW + 1 = 17
    div   = '1;
    data  = 8'h3C;
    valid = 1'b1;
    wait_ack("max_ack", 3, f0);
    valid = 1'b0;
    repeat (175) step();
    chk("max_byte", {24'd0, decode(f0, 17)}, 32'h3C);
    chk("max_busy_len", count_hi(1, f0, f0 + 175), 32'd170);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte serializer for the debug/calibration UART path. Accepts one 8-bit byte at a time from the frame generator over a valid/ack handshake and shifts it out as 8N1 asynchronous serial: idle high, one start bit, 8 data bits LSB first, one stop bit. Bit period is set at runtime by `div`. Its `tx` output drives the board UART pin that the host calibration script reads.

## Interface
- `DIV_W`, default 16: width of the `div` input.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-low reset. Asserting it (0) resets all state immediately; release is synchronised to `clk` by the top level.
- `data` in 8: byte to send; sampled only on the accept edge.
- `valid` in 1: a byte is available on `data`; may be held high continuously.
- `ack` out 1: one-cycle pulse meaning "byte accepted, present the next one".
- `div` in DIV_W: bit period minus 2, in `clk` cycles; bit period P = `div` + 2; baud = f_clk / P.
- `tx` out 1: serial line, idle high.
- `busy` out 1: high while a frame is in progress, from the start bit through the stop bit.

## Operation
- FSM states:
  - IDLE: `tx`=1, `busy`=0.
  - START: `tx`=0.
  - DATA: `tx` = `shreg[0]`.
  - STOP: `tx`=1.
- Accept: on a rising edge with state==IDLE and `valid`=1:
  - latch `data` into `shreg` and latch `div` into `div_q`;
  - clear the bit-cycle counter `cnt` and the bit index `bidx`;
  - go to START.
- `cnt` counts 0..`div_q`+1. When `cnt`==`div_q`+1 the current bit ends and `cnt` returns to 0.
- On each bit end:
  - START -> DATA.
  - DATA: shift `shreg` right by 1 and increment `bidx`. After the 8th bit (`bidx`==7) go to STOP.
  - STOP with `valid`=1: back-to-back accept. Latch new `data`/`div`, go straight to START, and pulse `ack`. No idle gap.
  - STOP with `valid`=0: go to IDLE.
- `ack` is registered. It is high for exactly the one cycle after an accept edge and low otherwise. Exactly one `ack` per frame.
- `div` changes mid-frame have no effect; `div_q` holds for the whole frame.
- `data` changes after the accept edge have no effect on the frame in flight.
- `valid` dropping mid-frame does not abort the frame.
- Arithmetic: `cnt` is DIV_W+1 bits wide so `div_q`+1 never overflows. With `div`=all-ones, P = 2^DIV_W + 1.
- Reset (`rst`=0), at any time including mid-frame:
  - state=IDLE, `tx`=1, `ack`=0, `busy`=0, `shreg`=0, `cnt`=0, `bidx`=0;
  - the partial frame is truncated and not resumed;
  - the first accept can happen on the first edge after release with `valid`=1.

## Timing
- Reset values: `tx`=1, `ack`=0, `busy`=0.
- Take the accept edge as edge E0. At E0, `tx` goes 0 and `busy` goes 1. `ack` is high in the cycle E0..E0+1.
- Start bit occupies edges E0..E0+P. Data bit k occupies E0+(k+1)·P .. E0+(k+2)·P. Stop bit occupies E0+9P .. E0+10P.
- Frame length is exactly 10·P cycles.
- Next accept edge, with `valid` held high: E0+10P.
- With `valid` low at the end of the stop bit: IDLE at E0+10P. The earliest next accept is E0+10P+1 (the edge after `valid` rises, while in IDLE).
- Upstream contract: upstream updates `data` within P−1 cycles after `ack`. This is trivially met, since the next sample point is 10P away.

## Test plan
- Single byte: `rst` released, `div`=10 (P=12), `data`=0xA5, `valid` pulsed one cycle.
  - `ack` is one pulse, in the cycle after acceptance.
  - `tx` sequence, 12 cycles each: 0, then 1,0,1,0,0,1,0,1, then 1. Total 120 cycles.
  - `busy` is high for exactly 120 cycles.
- Back-to-back: `valid` held at 1, upstream sequence 0xBE, 0xEF, 0x12, `div`=10.
  - Frames are contiguous, 120 cycles each, with no idle cycles between them.
  - `ack` pulses are exactly 120 cycles apart.
  - A host-model decoder recovers 0xBE, 0xEF, 0x12.
- Minimum divider: `div`=0 (P=2), `data`=0x00.
  - `tx` low for 18 cycles (start + 8 zeros), then high for 2.
  - The next accept occurs at cycle 20.
- Idle: `valid`=0 for 1000 cycles.
  - `tx`=1, `busy`=0, `ack`=0 throughout.
  - Changes on `data`/`div` cause no activity.
- Mid-frame changes: start 0x0F with `div`=10, change `div` to 2 and `data` to 0xFF during bit 3.
  - The 0x0F frame completes with P=12.
  - The next frame uses whatever `data`/`div` are present at its accept edge.
- Reset mid-frame: assert `rst`=0 during data bit 4, asynchronously (between edges).
  - `tx`=1 and `busy`=0 within the same cycle; no `ack`.
  - After release with `valid`=1 and `data`=0x55, a clean full frame starting with the start bit is sent.
